// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : RV32I instruction-fetch stage. Owns the architectural fetch
//               PC, issues word requests to instruction memory under a credit
//               limit, queues returned words in order and applies the PCSrc
//               redirect returned by decode (flushing wrong-path work and
//               discarding late responses).
//               Optional feature macro: FETCH_MISALIGN_TRAP_EN
//                 defined   -> misaligned redirect target halts fetch and
//                              raises fetch_fault until reset
//                 undefined -> target bits [1:0] are cleared, fault tied 0
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    output logic        fetch_fault
);

    localparam int               c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int               c_cnt_w = c_ptr_w + 1;
    localparam int               c_sum_w = c_cnt_w + 1;
    localparam logic [31:0]      c_nop   = 32'h0000_0013;
    localparam logic [c_sum_w-1:0] c_depth = c_sum_w'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        c_st_run  = 1'b0,
        c_st_halt = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [31:0]        r_fpc;          // next address to request
    logic [31:0]        r_resp_pc;      // address of next kept response
    logic               r_req_valid;
    logic [c_cnt_w-1:0] r_outstanding;  // accepted requests not yet answered
    logic [c_cnt_w-1:0] r_drop_cnt;     // stale responses still to discard
    logic [c_cnt_w-1:0] r_count;        // queue occupancy
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [31:0]        r_q_data [FIFO_DEPTH];
    logic [31:0]        r_q_addr [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic               w_run;
    logic               w_head_valid;
    logic [31:0]        w_head_pc;
    logic [31:0]        w_pc;
    logic               w_pop;
    logic               w_redirect;
    logic [31:0]        w_target_raw;
    logic [31:0]        w_target;
    logic               w_misalign;
    logic               w_req_fire;
    logic               w_resp_drop;
    logic               w_push;
    logic [c_cnt_w-1:0] w_out_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [c_cnt_w-1:0] w_drop_nxt;
    logic [c_sum_w-1:0] w_used;
    state_t             w_state_nxt;
    logic               w_req_nxt;

    assign w_run        = (r_state == c_st_run);
    assign w_head_valid = w_run && (r_count != '0);
    assign w_head_pc    = r_q_addr[r_rd_ptr];
    assign w_pop        = w_head_valid && instr_ready;

    // PCSrc 11 is reserved and behaves like 00 (sequential, no flush).
    assign w_redirect   = w_pop && ((PCSrc == 2'b01) || (PCSrc == 2'b10));
    assign w_target_raw = (PCSrc == 2'b01) ? (w_head_pc + ImmExt)
                                           : (ALUResult & 32'hFFFF_FFFE);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_target     = w_target_raw;
    assign w_misalign   = w_redirect && (w_target_raw[1:0] != 2'b00);
`else
    assign w_target     = w_target_raw & 32'hFFFF_FFFC;
    assign w_misalign   = 1'b0;
`endif

    assign w_req_fire   = r_req_valid && imem_req_ready;
    assign w_resp_drop  = imem_resp_valid && (r_drop_cnt != '0);

    // A response in the redirect cycle belongs to the wrong path, and
    // nothing is kept while halted.
    assign w_push       = imem_resp_valid && (r_drop_cnt == '0) && w_run && !w_redirect;

    // Outstanding count: +1 per accepted request, -1 per response.
    always_comb begin
        w_out_nxt = r_outstanding;
        if (w_req_fire && !imem_resp_valid) begin
            w_out_nxt = r_outstanding + c_cnt_w'(1);
        end else if (!w_req_fire && imem_resp_valid) begin
            w_out_nxt = r_outstanding - c_cnt_w'(1);
        end
    end

    // Queue occupancy: flushed on redirect, otherwise push/pop balance.
    always_comb begin
        w_cnt_nxt = r_count;
        if (w_redirect) begin
            w_cnt_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_cnt_nxt = r_count + c_cnt_w'(1);
        end else if (!w_push && w_pop) begin
            w_cnt_nxt = r_count - c_cnt_w'(1);
        end
    end

    // Every request still in flight after a redirect is wrong-path, including
    // one accepted in the redirect cycle itself.
    always_comb begin
        w_drop_nxt = r_drop_cnt;
        if (w_redirect) begin
            w_drop_nxt = w_out_nxt;
        end else if (w_resp_drop) begin
            w_drop_nxt = r_drop_cnt - c_cnt_w'(1);
        end
    end

    // Next-state and credit check for the registered request valid.
    always_comb begin
        w_state_nxt = r_state;
        if (w_misalign) begin
            w_state_nxt = c_st_halt;
        end
        w_used    = {1'b0, w_cnt_nxt} + {1'b0, w_out_nxt};
        w_req_nxt = (w_state_nxt == c_st_run) && !w_redirect && (w_used < c_depth);
    end

    // Control state, pointers and fetch/response address tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_st_run;
            r_fpc         <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_req_valid   <= 1'b0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_req_valid   <= w_req_nxt;
            r_outstanding <= w_out_nxt;
            r_drop_cnt    <= w_drop_nxt;
            r_count       <= w_cnt_nxt;
            if (w_redirect) begin
                r_fpc     <= w_target;
                r_resp_pc <= w_target;
                r_rd_ptr  <= '0;
                r_wr_ptr  <= '0;
            end else begin
                if (w_req_fire) begin
                    r_fpc <= r_fpc + 32'd4;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                    r_wr_ptr  <= r_wr_ptr + c_ptr_w'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                end
            end
        end
    end

    // Queue storage: kept responses with the address they were fetched from.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_data[r_wr_ptr] <= imem_resp_data;
            r_q_addr[r_wr_ptr] <= r_resp_pc;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_fault;

    // Sticky fault flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (w_misalign) begin
            r_fault <= 1'b1;
        end
    end

    assign fetch_fault = r_fault;
`else
    assign fetch_fault = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs: empty queue shows a nop at the current fetch pointer.
    // ------------------------------------------------------------------
    assign w_pc           = w_head_valid ? w_head_pc : r_fpc;
    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_fpc;
    assign instr_valid    = w_head_valid;
    assign Instr          = w_head_valid ? r_q_data[r_rd_ptr] : c_nop;
    assign PC             = w_pc;
    assign PCPlus4        = w_pc + 32'd4;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. An in-order memory with
//               random latency answers requests; a consumer pops with random
//               PCSrc choices. The reference is the architectural program
//               order: each consumed PC follows from the previous one and its
//               PCSrc, and each word must be the memory word at that PC.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  PCSrc;
    logic [31:0] ImmExt;
    logic [31:0] ALUResult;
    logic        fetch_fault;

    fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .Instr           (Instr),
        .PC              (PC),
        .PCPlus4         (PCPlus4),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .PCSrc           (PCSrc),
        .ImmExt          (ImmExt),
        .ALUResult       (ALUResult),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    // counters
    int n_vec = 0;
    int n_err = 0;

    // memory model: pending requests in order with due cycle
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          cyc;

    // stimulus knobs
    int lat_min, lat_max, p_rdy, p_ird, p_redir;
    bit          force_en;
    logic [1:0]  force_src;
    logic [31:0] force_imm, force_alu;
    bit          want_coincide, coincide_done;

    // reference model
    logic [31:0] exp_pc;
    logic [31:0] exp_req_addr;
    bit          prev_stall;
    logic [31:0] prev_addr;
    int          redir_age;
    int          n_fire, n_pop;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        #2;
        rst_n           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        instr_ready     = 1'b0;
        PCSrc           = 2'b00;
        ImmExt          = 32'd0;
        ALUResult       = 32'd0;
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", Instr, 32'h0000_0013);
        check("rst_pc", PC, RESET_PC);
        check("rst_pcplus4", PCPlus4, RESET_PC + 32'd4);
        check("rst_fault", 32'(fetch_fault), 32'd0);
        mq_addr.delete();
        mq_due.delete();
        exp_pc        = RESET_PC;
        exp_req_addr  = RESET_PC;
        prev_stall    = 1'b0;
        prev_addr     = RESET_PC;
        redir_age     = -1;
        n_fire        = 0;
        n_pop         = 0;
        force_en      = 1'b0;
        want_coincide = 1'b0;
        coincide_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // One clock cycle: called #1 after a rising edge, returns #1 after the next.
    task automatic run_cycle();
        logic [1:0]  src;
        logic [31:0] imm, alu, tgt;
        int          lat;
        bit          fire, pop;

        if (redir_age == 1) begin
            check("redir_bubble", 32'(imem_req_valid), 32'd0);
        end else if (prev_stall) begin
            check("req_hold_valid", 32'(imem_req_valid), 32'd1);
            check("req_hold_addr", imem_req_addr, prev_addr);
        end
        if (redir_age == 2) begin
            check("redir_reissue", 32'(imem_req_valid), 32'(mq_addr.size() < FIFO_DEPTH));
        end

        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        imem_req_ready = (int'($urandom_range(99)) < p_rdy);
        instr_ready    = (int'($urandom_range(99)) < p_ird);

        if (int'($urandom_range(99)) < p_redir) begin
            case ($urandom_range(9))
                0, 1, 2, 3: src = 2'b01;
                4, 5, 6, 7: src = 2'b10;
                8:          src = 2'b11;
                default:    src = 2'b00;
            endcase
        end else begin
            src = ($urandom_range(7) == 0) ? 2'b11 : 2'b00;
        end
        imm = 32'($urandom_range(2047)) - 32'd1024;
        alu = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                       : 32'($urandom_range(32'h3FFF));

        pop  = instr_valid && instr_ready;
        fire = imem_req_valid && imem_req_ready;
        if (want_coincide && pop && fire && imem_resp_valid) begin
            force_en      = 1'b1;
            force_src     = 2'b01;
            force_imm     = 32'h40;
            want_coincide = 1'b0;
            coincide_done = 1'b1;
        end
        if (force_en && pop) begin
            src      = force_src;
            imm      = force_imm;
            alu      = force_alu;
            force_en = 1'b0;
        end
        PCSrc     = src;
        ImmExt    = imm;
        ALUResult = alu;

        if (fire) begin
            check("req_addr", imem_req_addr, exp_req_addr);
            lat = int'($urandom_range(lat_max, lat_min));
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(cyc + lat);
            check("credit", 32'(mq_addr.size() <= FIFO_DEPTH), 32'd1);
            exp_req_addr = exp_req_addr + 32'd4;
            n_fire++;
        end
        if (pop) begin
            check("pc", PC, exp_pc);
            check("instr", Instr, mem_word(exp_pc));
            check("pcplus4", PCPlus4, exp_pc + 32'd4);
            n_pop++;
            if (src == 2'b01 || src == 2'b10) begin
                tgt          = (src == 2'b01) ? (exp_pc + imm) : alu;
                tgt          = tgt & 32'hFFFF_FFFC;
                exp_pc       = tgt;
                exp_req_addr = tgt;
                redir_age    = 0;
            end else begin
                exp_pc = exp_pc + 32'd4;
            end
        end
        prev_stall = imem_req_valid && !imem_req_ready;
        prev_addr  = imem_req_addr;

        @(posedge clk);
        #1;
        cyc++;
        if (redir_age >= 0) redir_age++;
        if (redir_age > 2) redir_age = -1;
    endtask

    task automatic set_knobs(input int lmin, input int lmax, input int rdy, input int ird, input int redir);
        lat_min = lmin;
        lat_max = lmax;
        p_rdy   = rdy;
        p_ird   = ird;
        p_redir = redir;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        force_alu = 32'd0;
        force_imm = 32'd0;
        force_src = 2'b00;

        // 1: streaming, latency 1
        set_knobs(1, 1, 100, 100, 0);
        do_reset();
        check("t1_c0_valid", 32'(imem_req_valid), 32'd0);
        run_cycle();
        check("t1_c1_valid", 32'(imem_req_valid), 32'd1);
        check("t1_c1_addr", imem_req_addr, 32'h0);
        run_cycle();
        check("t1_c2_addr", imem_req_addr, 32'h4);
        check("t1_c2_ivalid", 32'(instr_valid), 32'd0);
        run_cycle();
        check("t1_c3_ivalid", 32'(instr_valid), 32'd1);
        check("t1_c3_pc", PC, 32'h0);
        check("t1_c3_addr", imem_req_addr, 32'h8);
        repeat (20) run_cycle();

        // 2: consumer stalled, credits exhaust at FIFO_DEPTH
        set_knobs(1, 1, 100, 0, 0);
        do_reset();
        repeat (12) run_cycle();
        check("t2_fires", 32'(n_fire), 32'(FIFO_DEPTH));
        check("t2_req_idle", 32'(imem_req_valid), 32'd0);
        p_ird = 100;
        for (int i = 0; i < 20 && !imem_req_valid; i++) run_cycle();
        check("t2_resume_valid", 32'(imem_req_valid), 32'd1);
        check("t2_resume_addr", imem_req_addr, 32'h10);
        repeat (20) run_cycle();

        // 3: branch redirect from head PC 0x8, latency 3
        set_knobs(3, 3, 100, 100, 0);
        do_reset();
        for (int i = 0; i < 40 && !(instr_valid && PC == 32'h8); i++) run_cycle();
        check("t3_head_valid", 32'(instr_valid), 32'd1);
        check("t3_head_pc", PC, 32'h8);
        force_en  = 1'b1;
        force_src = 2'b01;
        force_imm = 32'h100;
        run_cycle();
        for (int i = 0; i < 40 && !instr_valid; i++) run_cycle();
        check("t3_first_pc", PC, 32'h108);
        check("t3_first_instr", Instr, mem_word(32'h108));

        // 4: jalr to misaligned target, then a wrapping target
        force_en  = 1'b1;
        force_src = 2'b10;
        force_alu = 32'h0000_0203;
        for (int i = 0; i < 40 && force_en; i++) run_cycle();
        for (int i = 0; i < 40 && !imem_req_valid; i++) run_cycle();
        check("t4_req_addr", imem_req_addr, 32'h200);
        check("t4_fault", 32'(fetch_fault), 32'd0);
        force_en  = 1'b1;
        force_src = 2'b10;
        force_alu = 32'hFFFF_FFF9;
        for (int i = 0; i < 40 && force_en; i++) run_cycle();
        repeat (30) run_cycle();
        check("t4_wrapped", 32'(exp_pc < 32'h100), 32'd1);

        // 5: ready toggling, redirect coinciding with response and handshake
        set_knobs(2, 2, 50, 100, 0);
        do_reset();
        want_coincide = 1'b1;
        for (int i = 0; i < 300 && !coincide_done; i++) run_cycle();
        check("t5_coincide", 32'(coincide_done), 32'd1);
        repeat (30) run_cycle();

        // 6: reset with three requests outstanding
        set_knobs(5, 5, 100, 0, 0);
        do_reset();
        for (int i = 0; i < 20 && mq_addr.size() != 3; i++) run_cycle();
        check("t6_outstanding", 32'(mq_addr.size()), 32'd3);
        do_reset();
        set_knobs(1, 3, 100, 100, 0);
        run_cycle();
        check("t6_restart_addr", imem_req_addr, RESET_PC);
        repeat (30) run_cycle();

        // random traffic
        set_knobs(1, 4, 70, 70, 30);
        do_reset();
        repeat (3000) run_cycle();
        check("rand_progress", 32'(n_pop > 200), 32'd1);
        check("fault_tied", 32'(fetch_fault), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
